// File: rtl/tc_counter_pkg.sv
// rtl/tc_counter_pkg.sv - shared encodings for the modulus counter
package tc_counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/tc_counter_next.sv
// rtl/tc_counter_next.sv - next-count and boundary detection for one counting edge
module tc_counter_next
    import tc_counter_pkg::*;
#(
    parameter int                   BIT_WIDTH = 8,
    parameter logic [BIT_WIDTH-1:0] MAX_VALUE = {BIT_WIDTH{1'b1}}
) (
    input  logic [BIT_WIDTH-1:0] count,
    input  logic [BIT_WIDTH-1:0] s,
    input  logic                 dir,
    input  logic [1:0]           mode,
    output logic [BIT_WIDTH-1:0] next_count,
    output logic                 boundary
);

    localparam logic [BIT_WIDTH:0] MAX_EXT = {1'b0, MAX_VALUE};
    localparam logic [BIT_WIDTH:0] MODULUS = MAX_EXT + 1'b1;

    logic [BIT_WIDTH:0] c_ext;
    logic [BIT_WIDTH:0] s_ext;
    logic [BIT_WIDTH:0] sum;
    logic [BIT_WIDTH:0] wide;
    logic               clamp;
    logic               sat;

    always_comb begin
        c_ext    = {1'b0, count};
        s_ext    = {1'b0, s};
        sum      = c_ext + s_ext;
        sat      = (mode == MODE_SAT);
        clamp    = sat || (mode == MODE_ONESHOT);
        wide     = c_ext;
        boundary = 1'b0;
        if (s_ext != '0) begin
            if (!dir) begin
                if (sum > MAX_EXT) begin
                    // A saturated counter already at the limit just sits there quietly
                    wide     = clamp ? MAX_EXT : sum - MODULUS;
                    boundary = !(sat && c_ext == MAX_EXT);
                end else begin
                    wide     = sum;
                    boundary = (sum == MAX_EXT);
                end
            end else begin
                if (s_ext > c_ext) begin
                    wide     = clamp ? '0 : c_ext + MODULUS - s_ext;
                    boundary = !(sat && c_ext == '0);
                end else begin
                    wide     = c_ext - s_ext;
                    boundary = (s_ext == c_ext);
                end
            end
        end
        next_count = BIT_WIDTH'(wide);
    end

endmodule

// File: rtl/tc_mod_counter.sv
// rtl/tc_mod_counter.sv - modulus counter with step, direction, end modes and one-shot FSM
module tc_mod_counter
    import tc_counter_pkg::*;
#(
    parameter int                   BIT_WIDTH = 8,
    parameter logic [BIT_WIDTH-1:0] MAX_VALUE = {BIT_WIDTH{1'b1}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 save,
    input  logic                 start,
    input  logic [BIT_WIDTH-1:0] in,
    input  logic                 dir,
    input  logic [BIT_WIDTH-1:0] step,
    input  logic [1:0]           mode,
    output logic [BIT_WIDTH-1:0] out,
    output logic                 tc,
    output logic                 running,
    output logic                 done
);

    state_t               state;
    logic [BIT_WIDTH-1:0] in_clamped;
    logic [BIT_WIDTH-1:0] s_eff;
    logic [BIT_WIDTH-1:0] next_count;
    logic                 boundary;
    logic                 oneshot;
    logic                 count_ok;

    assign in_clamped = (in > MAX_VALUE) ? MAX_VALUE : in;
    assign s_eff      = (step > MAX_VALUE) ? MAX_VALUE : step;
    assign oneshot    = (mode == MODE_ONESHOT);
    assign count_ok   = en && (!oneshot || state == RUN);

    tc_counter_next #(
        .BIT_WIDTH (BIT_WIDTH),
        .MAX_VALUE (MAX_VALUE)
    ) u_next (
        .count      (out),
        .s          (s_eff),
        .dir        (dir),
        .mode       (mode),
        .next_count (next_count),
        .boundary   (boundary)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            out     <= '0;
            tc      <= 1'b0;
            state   <= IDLE;
            running <= 1'b0;
            done    <= 1'b0;
        end else if (save) begin
            out     <= in_clamped;
            tc      <= 1'b0;
            state   <= IDLE;
            running <= 1'b0;
            done    <= 1'b0;
        end else if (start && oneshot) begin
            out     <= in_clamped;
            tc      <= 1'b0;
            state   <= RUN;
            running <= 1'b1;
            done    <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (count_ok) begin
                out <= next_count;
                tc  <= boundary;
            end
            // Leaving one-shot mode drops the FSM back to IDLE
            if (!oneshot) begin
                state   <= IDLE;
                running <= 1'b0;
                done    <= 1'b0;
            end else if (count_ok && boundary) begin
                state   <= DONE;
                running <= 1'b0;
                done    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tc_mod_counter.sv
// tb/tb_tc_mod_counter.sv - randomized and directed checks of tc_mod_counter against a reference model
module tb_tc_mod_counter;

    localparam int MAXV = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       save = 1'b0;
    logic       start = 1'b0;
    logic [7:0] in = '0;
    logic       dir = 1'b0;
    logic [7:0] step = '0;
    logic [1:0] mode = '0;
    logic [7:0] out;
    logic       tc;
    logic       running;
    logic       done;

    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;

    // model: count value, tc flag, phase 0 = idle, 1 = run, 2 = done
    int m_out = 0;
    int m_tc = 0;
    int m_ph = 0;

    tc_mod_counter #(.BIT_WIDTH(8), .MAX_VALUE(8'd9)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .save    (save),
        .start   (start),
        .in      (in),
        .dir     (dir),
        .step    (step),
        .mode    (mode),
        .out     (out),
        .tc      (tc),
        .running (running),
        .done    (done)
    );

    always #5 clk = ~clk;

    function automatic int min_int(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void model_step();
        int s;
        int t;
        int hit;
        bit limited;
        if (!rst) begin
            m_out = 0; m_tc = 0; m_ph = 0;
        end else if (save) begin
            m_out = min_int(int'(in), MAXV); m_tc = 0; m_ph = 0;
        end else if (start && mode == 2'd2) begin
            m_out = min_int(int'(in), MAXV); m_tc = 0; m_ph = 1;
        end else begin
            m_tc = 0;
            if (mode != 2'd2) m_ph = 0;
            if (en && (mode != 2'd2 || m_ph == 1)) begin
                s = min_int(int'(step), MAXV);
                limited = (mode == 2'd1) || (mode == 2'd2);
                hit = 0;
                if (s != 0) begin
                    t = dir ? m_out - s : m_out + s;
                    if (t > MAXV || t < 0) begin
                        hit = 1;
                        if (!limited) m_out = (t + (MAXV + 1)) % (MAXV + 1);
                        else begin
                            if (mode == 2'd1 && m_out == (dir ? 0 : MAXV)) hit = 0;
                            m_out = dir ? 0 : MAXV;
                        end
                    end else begin
                        m_out = t;
                        hit = (t == (dir ? 0 : MAXV)) ? 1 : 0;
                    end
                end
                m_tc = hit;
                if (mode == 2'd2 && hit == 1) m_ph = 2;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            checks = checks + 1;
            if (out !== 8'(m_out) || tc !== (m_tc != 0) ||
                running !== (m_ph == 1) || done !== (m_ph == 2)) begin
                failures = failures + 1;
                $display("FAIL model_cmp t=%0t actual out=%0d tc=%b run=%b done=%b required out=%0d tc=%0d run=%0d done=%0d",
                         $time, out, tc, running, done, m_out, m_tc, m_ph == 1, m_ph == 2);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
        end
        #1;
    endtask

    task automatic lit(input string name, input int got, input int exp);
        checks = checks + 1;
        if (got != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d required=%0d", name, got, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        tick(1);
        chk_on = 1'b1;
        lit("reset_out", int'(out), 0);
        lit("reset_flags", int'({tc, running, done}), 0);

        rst = 1'b1; mode = 2'd0; dir = 1'b0; step = 8'd1; en = 1'b1;
        tick(9);
        lit("wrap_up_9", int'(out), 9);
        lit("wrap_up_9_tc", int'(tc), 1);
        tick(1);
        lit("wrap_up_0", int'(out), 0);
        lit("wrap_up_0_tc", int'(tc), 1);

        save = 1'b1; in = 8'd2; dir = 1'b1; step = 8'd3;
        tick(1);
        save = 1'b0;
        lit("wrap_dn_load", int'(out), 2);
        tick(1);
        lit("wrap_dn_9", int'(out), 9);
        lit("wrap_dn_9_tc", int'(tc), 1);
        tick(3);
        lit("wrap_dn_0_tc", int'({out, tc}), 1);
        tick(1);
        lit("wrap_dn_7", int'(out), 7);

        save = 1'b1; in = 8'd5; mode = 2'd1; dir = 1'b0; step = 8'd4;
        tick(1);
        save = 1'b0;
        tick(1);
        lit("sat_up_9_tc", int'({out, tc}), 19);
        tick(3);
        lit("sat_hold_9", int'({out, tc}), 18);
        dir = 1'b1;
        tick(3);
        lit("sat_dn_0_tc", int'({out, tc}), 1);
        tick(1);
        lit("sat_dn_hold", int'({out, tc}), 0);

        mode = 2'd2; dir = 1'b0; step = 8'd1; start = 1'b1; in = 8'd7;
        tick(1);
        start = 1'b0;
        lit("os_run", int'({out, running}), 15);
        tick(2);
        lit("os_done", int'({out, tc, done}), 39);
        tick(2);
        lit("os_hold", int'({out, tc, done, running}), 74);
        start = 1'b1; in = 8'd0;
        tick(1);
        start = 1'b0;
        lit("os_rearm", int'({out, running}), 1);

        save = 1'b1; start = 1'b1; in = 8'd12;
        tick(1);
        save = 1'b0; start = 1'b0;
        lit("save_start", int'({out, running, done}), 36);
        en = 1'b0; mode = 2'd0;
        tick(3);
        lit("en_freeze", int'(out), 9);
        en = 1'b1; step = 8'd0;
        tick(2);
        lit("step0_hold", int'({out, tc}), 18);

        mode = 2'd2; step = 8'd1; start = 1'b1; in = 8'd3;
        tick(1);
        start = 1'b0;
        tick(1);
        lit("mid_run", int'({out, running}), 9);
        rst = 1'b0; save = 1'b1; in = 8'd5;
        tick(1);
        lit("rst_mid", int'({out, tc, running, done}), 0);
        rst = 1'b1; save = 1'b0;
        #1;
        lit("rst_release", int'({out, tc, running, done}), 0);

        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 99) != 0);
            save  = ($urandom_range(0, 99) < 5);
            start = ($urandom_range(0, 99) < 6);
            en    = ($urandom_range(0, 99) < 85);
            dir   = ($urandom_range(0, 3) == 0) ? ~dir : dir;
            in    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0)
                step = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
            if ($urandom_range(0, 15) == 0)
                mode = 2'($urandom_range(0, 3));
            tick(1);
        end

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
